sume: RTL and testbench

SUME -- requirements
Module: sume

---
 rtl/sume_pkg.sv | 49 ++++
 rtl/sume_key_detect.sv | 88 ++++++++
 rtl/sume.sv | 86 ++++++++
 tb/tb_sume.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sume_pkg.sv
// Shared types and constants for the SUME keypad adder.
// Holds the FSM state encoding, keypad codes, datapath widths and BCD helpers.
package sume_pkg;

    localparam int DIGIT_W   = 4;
    localparam int OPERAND_W = 10;
    localparam int RESULT_W  = 12;

    localparam logic [DIGIT_W-1:0] NO_KEY = 4'hF;

    typedef enum logic [2:0] {
        W1_D2 = 3'd0,
        W1_D1 = 3'd1,
        W1_D0 = 3'd2,
        W2_D2 = 3'd3,
        W2_D1 = 3'd4,
        W2_D0 = 3'd5,
        SUM   = 3'd6
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } bcd3_t;

    // True for the decimal digit codes 0-9.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return code <= 4'd9;
    endfunction

    // Codes the input register accepts: digits and the no-key code.
    // Codes A-E are invalid and leave the registered key untouched.
    function automatic logic is_key_code(input logic [DIGIT_W-1:0] code);
        return is_digit(code) || (code == NO_KEY);
    endfunction

    // Three BCD digits to binary, d2*100 + d1*10 + d0 (max 999).
    function automatic logic [OPERAND_W-1:0] bcd_to_bin(input bcd3_t v);
        logic [OPERAND_W-1:0] h;
        logic [OPERAND_W-1:0] t;
        logic [OPERAND_W-1:0] u;
        h = OPERAND_W'(v.d2);
        t = OPERAND_W'(v.d1);
        u = OPERAND_W'(v.d0);
        return (h * OPERAND_W'(100)) + (t * OPERAND_W'(10)) + u;
    endfunction

endpackage

// File: rtl/sume_key_detect.sv
// Keypad front end: registers the raw keypad code, optionally debounces it
// (SUME_DEBOUNCE_EN) and emits a one-cycle valid pulse per new digit press.
// Invalid codes A-E never reach key_q, so a digit held across an invalid
// glitch still counts as a single press.
module sume_key_detect
    import sume_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] sample_input,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid
);

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [DIGIT_W-1:0] key_q;
    logic [DIGIT_W-1:0] key_d;
    logic [DIGIT_W-1:0] prev_q;
    logic [DIGIT_W-1:0] prev_d;

`ifdef SUME_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DIGIT_W-1:0] samp_q;
    logic [DIGIT_W-1:0] samp_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Count how long the sampled code has been stable; promote it to key_q once stable long enough.
    always_comb begin
        samp_d = sample_input;
        cnt_d  = cnt_q;
        key_d  = key_q;
        if (sample_input != samp_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_q == CNT_LAST) && is_key_code(samp_q)) begin
            key_d = samp_q;
        end
    end

    // Debounce sampling register and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= NO_KEY;
            cnt_q  <= '0;
        end else begin
            samp_q <= samp_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // Register the raw code directly, ignoring invalid codes.
    always_comb begin
        key_d = key_q;
        if (is_key_code(sample_input)) begin
            key_d = sample_input;
        end
    end
`endif

    // Remember last cycle's key and flag a press when a digit appears that differs from it.
    always_comb begin
        prev_d = key_q;
        digit  = key_q;
        valid  = is_digit(key_q) && (key_q != prev_q);
    end

    // Registered key and its one-cycle-delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= NO_KEY;
            prev_q <= NO_KEY;
        end else begin
            key_q  <= key_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/sume.sv
// SUME top: collects two 3-digit decimal operands from keypad presses and
// presents their binary sum on cdu. Optional input debounce is enabled by
// defining SUME_DEBOUNCE_EN.
module sume
    import sume_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGIT_W-1:0]  sample_input,
    output logic [RESULT_W-1:0] cdu
);

    logic [DIGIT_W-1:0]  key_digit;
    logic                key_valid;

    state_t              state_q;
    state_t              state_d;
    bcd3_t               w1_q;
    bcd3_t               w1_d;
    bcd3_t               w2_q;
    bcd3_t               w2_d;
    logic [RESULT_W-1:0] cdu_q;
    logic [RESULT_W-1:0] cdu_d;
    logic [OPERAND_W:0]  sum_bin;

    sume_key_detect #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_detect (
        .clk          (clk),
        .rst          (rst),
        .sample_input (sample_input),
        .digit        (key_digit),
        .valid        (key_valid)
    );

    // 11-bit sum of both operands converted from BCD.
    always_comb begin
        sum_bin = {1'b0, bcd_to_bin(w1_q)} + {1'b0, bcd_to_bin(w2_q)};
    end

    // Digit-entry FSM: each press fills the next digit; SUM loads cdu and may accept the next hundreds digit.
    always_comb begin
        state_d = state_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        cdu_d   = cdu_q;
        case (state_q)
            W1_D2: if (key_valid) begin w1_d.d2 = key_digit; state_d = W1_D1; end
            W1_D1: if (key_valid) begin w1_d.d1 = key_digit; state_d = W1_D0; end
            W1_D0: if (key_valid) begin w1_d.d0 = key_digit; state_d = W2_D2; end
            W2_D2: if (key_valid) begin w2_d.d2 = key_digit; state_d = W2_D1; end
            W2_D1: if (key_valid) begin w2_d.d1 = key_digit; state_d = W2_D0; end
            W2_D0: if (key_valid) begin w2_d.d0 = key_digit; state_d = SUM;   end
            SUM: begin
                cdu_d = RESULT_W'(sum_bin);
                if (key_valid) begin
                    w1_d.d2 = key_digit;
                    state_d = W1_D1;
                end else begin
                    state_d = W1_D2;
                end
            end
            default: state_d = W1_D2;
        endcase
    end

    // FSM state, operand digits and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= W1_D2;
            w1_q    <= '0;
            w2_q    <= '0;
            cdu_q   <= '0;
        end else begin
            state_q <= state_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            cdu_q   <= cdu_d;
        end
    end

    assign cdu = cdu_q;

endmodule

// File: tb/tb_sume.sv
// Self-checking bench for sume (default build, no debounce).
// Keeps a digit-level model: every new digit press is queued, and each
// group of six digits forms two decimal operands whose sum cdu must show.
module tb_sume;
    import sume_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  sample_input;
    logic [11:0] cdu;

    int          n_total;
    int          n_pass;

    int          digs[$];
    logic [3:0]  last_key;
    logic [11:0] exp_cdu;

    sume #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_input (sample_input),
        .cdu          (cdu)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare a result value and record the outcome.
    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: cdu observed %0d (0x%03h), expected %0d (0x%03h)", tag, obs, obs, exp, exp);
    endtask

    // Compare the FSM state and record the outcome.
    task automatic checkState(input string tag, input state_t obs, input state_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: state observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Model reset: partial operands dropped, sum cleared.
    task automatic modelReset();
        digs.delete();
        last_key = 4'hF;
        exp_cdu  = 12'd0;
    endtask

    // Drive one keypad code for 'hold' cycles (called at a negedge) and check cdu.
    task automatic applyStimulus(input string tag, input logic [3:0] code, input int hold);
        bit          completes;
        logic [11:0] prev_cdu;
        int          a;
        int          b;
        completes = 0;
        prev_cdu  = exp_cdu;
        if (code <= 4'd9 || code == 4'hF) begin
            if (code <= 4'd9 && code != last_key) begin
                digs.push_back(int'(code));
                if (digs.size() == 6) begin
                    a = digs[0] * 100 + digs[1] * 10 + digs[2];
                    b = digs[3] * 100 + digs[4] * 10 + digs[5];
                    exp_cdu   = 12'(a + b);
                    completes = 1;
                    digs.delete();
                end
            end
            last_key = code;
        end
        sample_input = code;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (completes && hold >= 3 && i == 2) checkOutput({tag, "_before"}, cdu, prev_cdu);
            if (completes && hold >= 3 && i == 3) checkOutput({tag, "_latency"}, cdu, exp_cdu);
        end
        if (hold >= 3) checkOutput(tag, cdu, exp_cdu);
    endtask

    // Hold reset for a given number of cycles with no key pressed.
    task automatic pulseReset(input int cycles);
        sample_input = 4'hF;
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [3:0] seq[6];
        int         r;
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        sample_input = 4'hF;
        modelReset();
        @(negedge clk);

        $display("[TB] reset and idle");
        pulseReset(3);
        checkOutput("reset_cdu", cdu, 12'd0);
        checkState("reset_state", dut.state_q, W1_D2);
        repeat (50) @(negedge clk);
        checkOutput("idle_cdu", cdu, 12'd0);
        checkState("idle_state", dut.state_q, W1_D2);

        $display("[TB] 123 + 123");
        seq = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
        foreach (seq[i]) applyStimulus("sum_123_123", seq[i], 27);
        applyStimulus("release", 4'hF, 5);
        checkOutput("sum_246", cdu, 12'h0F6);

        $display("[TB] 321 + 321");
        seq = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
        foreach (seq[i]) applyStimulus("sum_321_321", seq[i], 27);
        checkOutput("sum_642", cdu, 12'h282);

        $display("[TB] 534 + 961 and 999 + 999");
        seq = '{4'd5, 4'd3, 4'd4, 4'd9, 4'd6, 4'd1};
        foreach (seq[i]) applyStimulus("sum_534_961", seq[i], 6);
        checkOutput("sum_1495", cdu, 12'h5D7);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("nines_gap", 4'hF, 3);
            applyStimulus("sum_999_999", 4'd9, 4);
        end
        checkOutput("sum_1998", cdu, 12'h7CE);
        applyStimulus("release", 4'hF, 3);

        $display("[TB] invalid code between identical digits");
        applyStimulus("hold_1", 4'd1, 5);
        applyStimulus("invalid_a", 4'hA, 5);
        applyStimulus("hold_1_again", 4'd1, 5);
        checkState("single_event_state", dut.state_q, W1_D1);
        checkOutput("single_event_cdu", cdu, 12'h7CE);
        seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
        for (int i = 0; i < 5; i++) applyStimulus("after_invalid", seq[i], 4);
        checkOutput("sum_123_456", cdu, 12'd579);

        $display("[TB] reset mid-entry");
        applyStimulus("partial_7", 4'd7, 4);
        applyStimulus("partial_8", 4'd8, 4);
        applyStimulus("partial_rel", 4'hF, 3);
        pulseReset(1);
        @(negedge clk);
        checkOutput("mid_reset_cdu", cdu, 12'd0);
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        foreach (seq[i]) applyStimulus("after_reset", seq[i], 4);
        checkOutput("sum_579", cdu, 12'h243);

        $display("[TB] press arriving during SUM");
        applyStimulus("rel", 4'hF, 3);
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        for (int i = 0; i < 5; i++) applyStimulus("sum_evt_a", seq[i], 4);
        applyStimulus("sum_evt_6", 4'd6, 1);
        seq = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3};
        foreach (seq[i]) applyStimulus("sum_evt_b", seq[i], 4);
        checkOutput("sum_912", cdu, 12'd912);

        $display("[TB] randomized entry");
        for (int op = 0; op < 30; op++) begin
            r = int'($urandom_range(0, 3));
            if (r == 1) applyStimulus("rnd_nokey", 4'hF, int'($urandom_range(1, 4)));
            if (r == 2) applyStimulus("rnd_invalid", 4'(10 + $urandom_range(0, 4)), int'($urandom_range(1, 4)));
            applyStimulus("rnd_digit", 4'($urandom_range(0, 9)), int'($urandom_range(3, 10)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
